// File: rtl/sk9822_rx.sv
// rtl/sk9822_rx.sv - SK9822 serial LED stream receiver
// Decodes start/data/end frames from a sniffed CK/DA pair into per-LED pulses.
module sk9822_rx #(
  parameter int MAX_LED     = 12,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sk9822_ck,
  input  logic        sk9822_da,
  output logic        led_valid,
  output logic [6:0]  led_idx,
  output logic [4:0]  led_bright,
  output logic [23:0] led_rgb,
  output logic        frame_start,
  output logic        frame_end,
  output logic        frame_err,
  output logic [6:0]  led_count
);

  localparam int             IW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0]  IDLE_MAX = IW'(TIMEOUT_CYC);
  localparam logic [IW-1:0]  IDLE_ONE = IW'(1);
  localparam logic [6:0]     LED_MAX  = 7'(MAX_LED);

  typedef enum logic {HUNT, WORD} state_t;

  state_t        state, state_n;
  logic          ck_s1, ck_s2, ck_prev, da_s1, da_s2;
  logic [31:0]   shreg;
  logic [5:0]    zero_cnt, zero_n;
  logic [4:0]    bit_cnt, bit_n;
  logic [6:0]    idx_cnt, idx_n;
  logic [IW-1:0] idle_cnt, idle_n;
  logic [6:0]    led_idx_n, led_count_n;
  logic [4:0]    bright_n;
  logic [23:0]   rgb_n;
  logic          valid_n, start_n, end_n, err_n;
  logic          ck_rise;
  logic [31:0]   word_in;

  assign ck_rise = ck_s2 & ~ck_prev;
  // Word as it will look once the current bit is shifted in
  assign word_in = {shreg[30:0], da_s2};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ck_s1   <= 1'b0;
      ck_s2   <= 1'b0;
      ck_prev <= 1'b0;
      da_s1   <= 1'b0;
      da_s2   <= 1'b0;
      shreg   <= '0;
    end else begin
      ck_s1   <= sk9822_ck;
      ck_s2   <= ck_s1;
      ck_prev <= ck_s2;
      da_s1   <= sk9822_da;
      da_s2   <= da_s1;
      if (ck_rise) shreg <= word_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      zero_cnt    <= '0;
      bit_cnt     <= '0;
      idx_cnt     <= '0;
      idle_cnt    <= '0;
      led_valid   <= 1'b0;
      led_idx     <= '0;
      led_bright  <= '0;
      led_rgb     <= '0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_err   <= 1'b0;
      led_count   <= '0;
    end else begin
      state       <= state_n;
      zero_cnt    <= zero_n;
      bit_cnt     <= bit_n;
      idx_cnt     <= idx_n;
      idle_cnt    <= idle_n;
      led_valid   <= valid_n;
      led_idx     <= led_idx_n;
      led_bright  <= bright_n;
      led_rgb     <= rgb_n;
      frame_start <= start_n;
      frame_end   <= end_n;
      frame_err   <= err_n;
      led_count   <= led_count_n;
    end
  end

  always_comb begin
    state_n     = state;
    zero_n      = zero_cnt;
    bit_n       = bit_cnt;
    idx_n       = idx_cnt;
    led_idx_n   = led_idx;
    bright_n    = led_bright;
    rgb_n       = led_rgb;
    led_count_n = led_count;
    valid_n     = 1'b0;
    start_n     = 1'b0;
    end_n       = 1'b0;
    err_n       = 1'b0;
    if (ck_rise)                  idle_n = '0;
    else if (idle_cnt == IDLE_MAX) idle_n = idle_cnt;
    else                          idle_n = idle_cnt + IDLE_ONE;

    case (state)
      HUNT: begin
        if (ck_rise) begin
          if (da_s2) begin
            zero_n = '0;
          end else if (zero_cnt == 6'd31) begin
            start_n   = 1'b1;
            idx_n     = '0;
            led_idx_n = '0;
            bit_n     = '0;
            zero_n    = '0;
            state_n   = WORD;
          end else begin
            zero_n = zero_cnt + 6'd1;
          end
        end
      end
      WORD: begin
        zero_n = '0;
        if (ck_rise) begin
          bit_n = bit_cnt + 5'd1;
          if (bit_cnt == 5'd31) begin
            if (word_in == 32'h0000_0000) begin
              start_n   = 1'b1;
              idx_n     = '0;
              led_idx_n = '0;
            end else if (&word_in) begin
              end_n       = 1'b1;
              led_count_n = idx_cnt;
              state_n     = HUNT;
            end else if (word_in[31:29] == 3'b111) begin
              if (idx_cnt < LED_MAX) begin
                valid_n   = 1'b1;
                led_idx_n = idx_cnt;
                bright_n  = word_in[28:24];
                rgb_n     = word_in[23:0];
                idx_n     = idx_cnt + 7'd1;
              end else begin
                err_n = 1'b1;
              end
            end else begin
              err_n   = 1'b1;
              state_n = HUNT;
            end
          end
        end else if (idle_cnt == IDLE_MAX) begin
          // Bus went quiet mid-packet: drop the partial word silently
          state_n = HUNT;
          bit_n   = '0;
        end
      end
      default: state_n = HUNT;
    endcase
  end

endmodule

// File: tb/tb_sk9822_rx.sv
// tb/tb_sk9822_rx.sv - self-checking bench for sk9822_rx
// Word-level reference model predicts the pulse stream for randomized packets.
module tb_sk9822_rx;
  localparam int MAX_LED = 12;
  localparam int TO      = 3000;

  logic        clk = 1'b0;
  logic        rst, ck, da;
  logic        led_valid, frame_start, frame_end, frame_err;
  logic [6:0]  led_idx, led_count;
  logic [4:0]  led_bright;
  logic [23:0] led_rgb;

  always #5 clk = ~clk;

  sk9822_rx #(.MAX_LED(MAX_LED), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .sk9822_ck(ck), .sk9822_da(da),
    .led_valid(led_valid), .led_idx(led_idx), .led_bright(led_bright),
    .led_rgb(led_rgb), .frame_start(frame_start), .frame_end(frame_end),
    .frame_err(frame_err), .led_count(led_count)
  );

  int checks = 0, failures = 0;

  logic [35:0] obs_valid[$];
  int obs_start, obs_end, obs_err, multi;

  logic [35:0] exp_valid[$];
  int exp_start, exp_end, exp_err, m_idx;
  bit m_word;
  logic [6:0] exp_count;

  always @(negedge clk) begin
    if (!rst) begin
      if (led_valid) obs_valid.push_back({led_idx, led_bright, led_rgb});
      obs_start += 32'(frame_start);
      obs_end   += 32'(frame_end);
      obs_err   += 32'(frame_err);
      if (32'(led_valid) + 32'(frame_start) + 32'(frame_end) + 32'(frame_err) > 1) multi++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_all();
    obs_valid.delete(); exp_valid.delete();
    obs_start = 0; obs_end = 0; obs_err = 0;
    exp_start = 0; exp_end = 0; exp_err = 0;
  endtask

  task automatic send_bit(input bit b);
    da = b;
    repeat (4) @(posedge clk);
    #1 ck = 1'b1;
    repeat (4) @(posedge clk);
    #1 ck = 1'b0;
  endtask

  task automatic model_word(input logic [31:0] w);
    if (!m_word) begin
      if (w == 32'h0) begin exp_start++; m_idx = 0; m_word = 1; end
    end else if (w == 32'h0) begin
      exp_start++; m_idx = 0;
    end else if (w == 32'hFFFF_FFFF) begin
      exp_end++; exp_count = 7'(m_idx); m_word = 0;
    end else if (w[31:29] == 3'b111) begin
      if (m_idx < MAX_LED) begin
        exp_valid.push_back({7'(m_idx), w[28:0]});
        m_idx++;
      end else exp_err++;
    end else begin
      exp_err++; m_word = 0;
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
    model_word(w);
  endtask

  function automatic logic [31:0] rand_data();
    logic [31:0] w;
    w = {3'b111, 29'($urandom)};
    if (&w) w[0] = 1'b0;
    return w;
  endfunction

  task automatic compare(input string tag);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check({tag, ".nvalid"}, 64'(obs_valid.size()), 64'(exp_valid.size()));
    for (int i = 0; i < exp_valid.size() && i < obs_valid.size(); i++)
      check($sformatf("%s.valid%0d", tag, i), 64'(obs_valid[i]), 64'(exp_valid[i]));
    check({tag, ".start"}, 64'(obs_start), 64'(exp_start));
    check({tag, ".end"},   64'(obs_end),   64'(exp_end));
    check({tag, ".err"},   64'(obs_err),   64'(exp_err));
    check({tag, ".count"}, 64'(led_count), 64'(exp_count));
  endtask

  initial begin
    logic [31:0] pw;
    int n;
    rst = 1'b1; ck = 1'b0; da = 1'b0;
    m_word = 0; m_idx = 0; exp_count = '0; multi = 0;
    clear_all();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'({led_valid, led_idx, led_bright, led_rgb,
                                frame_start, frame_end, frame_err, led_count}), 64'(0));
    #1 rst = 1'b0;

    // 31 zeros, a one, then 32 zeros: start only on the very last zero
    for (int i = 0; i < 31; i++) send_bit(1'b0);
    send_bit(1'b1);
    for (int i = 0; i < 31; i++) send_bit(1'b0);
    repeat (10) @(posedge clk);
    check("hunt_no_early_start", 64'(obs_start), 64'(0));
    send_bit(1'b0);
    repeat (10) @(posedge clk);
    check("hunt_start_on_last_zero", 64'(obs_start), 64'(1));
    clear_all();
    m_word = 1; m_idx = 0;
    send_word(32'hFFFF_FFFF);
    compare("hunt_then_end");

    // Full packet of 12 identical LEDs
    clear_all();
    send_word(32'h0);
    for (int i = 0; i < 12; i++) send_word(32'hEF00_0001);
    send_word(32'hFFFF_FFFF);
    compare("pkt12");
    check("pkt12.led_count", 64'(led_count), 64'(12));

    // 13 frames: last overflows
    clear_all();
    send_word(32'h0);
    for (int i = 0; i < 13; i++) send_word(rand_data());
    send_word(32'hFFFF_FFFF);
    compare("overflow13");
    check("overflow13.err", 64'(obs_err), 64'(1));

    // Bad header then recovery
    clear_all();
    send_word(32'h0);
    send_word(32'h6F12_3456);
    send_word(32'h0);
    send_word(rand_data());
    send_word(32'hFFFF_FFFF);
    compare("bad_header");

    // Partial word then timeout
    clear_all();
    send_word(32'h0);
    pw = 32'hEF00_0001;
    for (int i = 31; i > 11; i--) send_bit(pw[i]);
    repeat (TO + 10) @(posedge clk);
    m_word = 0;
    send_word(32'h0);
    for (int i = 0; i < 3; i++) send_word(rand_data());
    send_word(32'hFFFF_FFFF);
    compare("timeout");
    check("timeout.led_count", 64'(led_count), 64'(3));

    // Reset in the middle of a data frame
    clear_all();
    send_word(32'h0);
    pw = rand_data();
    for (int i = 31; i > 15; i--) send_bit(pw[i]);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midword_reset_outputs", 64'({led_valid, led_idx, led_bright, led_rgb,
                                        frame_start, frame_end, frame_err, led_count}), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    m_word = 0; exp_count = '0;
    clear_all();
    send_word(32'h0);
    for (int i = 0; i < 2; i++) send_word(rand_data());
    send_word(32'hFFFF_FFFF);
    compare("after_reset");
    check("after_reset.led_count", 64'(led_count), 64'(2));

    // Randomized packets, sometimes with a repeated start frame
    for (int r = 0; r < 4; r++) begin
      clear_all();
      n = int'($urandom_range(0, 14));
      send_word(32'h0);
      if ($urandom_range(0, 1) == 1) send_word(32'h0);
      for (int i = 0; i < n; i++) send_word(rand_data());
      send_word(32'hFFFF_FFFF);
      compare($sformatf("rand%0d", r));
    end

    check("at_most_one_pulse", 64'(multi), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sk9822_rx.md
SK9822_RX -- requirements
Module: sk9822_rx

Interface
REQ-001 Parameter MAX_LED, default 12, number of LED data frames accepted per packet.
REQ-002 Parameter TIMEOUT_CYC, default 100000, clk cycles without a CK rising edge before the block returns to hunt.
REQ-003 clk  input  1  single system clock (27 MHz nominal); all logic on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 sk9822_ck  input  1  serial clock from the SK9822 chain; asynchronous to clk.
REQ-006 sk9822_da  input  1  serial data, MSB first; sampled on CK rising edge.
REQ-007 led_valid  output  1  one-clk pulse; an LED data frame was decoded.
REQ-008 led_idx  output  7  0-based LED position of the current data frame, valid with led_valid.
REQ-009 led_bright  output  5  global brightness field, frame bits [28:24].
REQ-010 led_rgb  output  24  colour field, frame bits [23:0], in received order.
REQ-011 frame_start  output  1  one-clk pulse; a 32-bit all-zero start frame was received.
REQ-012 frame_end  output  1  one-clk pulse; a 32-bit all-one end frame was received.
REQ-013 frame_err  output  1  one-clk pulse; malformed frame or LED overflow.
REQ-014 led_count  output  7  data frames in the last packet closed by an end frame; held until the next end frame.

Function
REQ-015 sk9822_ck and sk9822_da each pass through an identical 2-flop synchronizer; a CK rising edge is detected when the synced CK is 1 and its previous value was 0.
REQ-016 On each detected CK edge, the synced DA is shifted into a 32-bit shift register, LSB in, MSB first.
REQ-017 States: HUNT, WORD. Reset enters HUNT.
REQ-018 HUNT: a counter counts consecutive 0 bits, clearing on any 1 bit and saturating at 32. On the 32nd consecutive 0: pulse frame_start, clear led_idx, clear the bit counter, enter WORD.
REQ-019 WORD: a 5-bit bit counter increments per CK edge. On the 32nd bit the completed word is classified, and the counter wraps to 0.
REQ-020 Word 0x00000000: pulse frame_start, clear led_idx, stay in WORD (repeated start frames are legal).
REQ-021 Word 0xFFFFFFFF: classified as an end frame, never as data. Pulse frame_end, load led_count from led_idx, enter HUNT.
REQ-022 Any other word with bits [31:29] = 3'b111, while led_idx < MAX_LED: drive led_bright and led_rgb, pulse led_valid with the current led_idx, then increment led_idx; stay in WORD.
REQ-023 Same as REQ-022 but with led_idx = MAX_LED: no led_valid, pulse frame_err, stay in WORD, led_idx unchanged.
REQ-024 Any other word (header not 111): pulse frame_err, enter HUNT.
REQ-025 Latency: every output pulse asserts exactly one clk after the clk in which the 32nd bit's CK edge is detected.
REQ-026 led_bright, led_rgb and led_idx hold their values between pulses.
REQ-027 An idle counter clears on each CK edge. When it reaches TIMEOUT_CYC in WORD, enter HUNT with no pulse and discard the partial word. The counter saturates in HUNT.
REQ-028 At most one of led_valid, frame_start, frame_end, frame_err is high in any clk.
REQ-029 DA must be stable for at least 3 clk around the CK rising edge; shorter setup is outside the supported range.

Reset
REQ-030 rst asserted: all outputs 0, state HUNT, all counters, the shift register and the synchronizer flops cleared, asynchronously.
REQ-031 rst asserted mid-word: the partial word is discarded and no pulse is generated for it after release.

Verification
REQ-032 Send start frame, 12 frames 0xEF000001, end frame -> frame_start once; 12 led_valid with led_idx 0..11, led_bright 0x0F, led_rgb 0x000001; frame_end; led_count = 12.
REQ-033 Send start frame, 13 data frames, end frame -> 12 led_valid, one frame_err at the 13th frame, frame_end, led_count = 12.
REQ-034 Send start frame, then word 0x6F123456 -> frame_err pulse, no led_valid; a following start frame pulses frame_start again.
REQ-035 Send start frame, then 20 data bits, then idle for TIMEOUT_CYC+10 clk, then a new full packet of 3 LEDs -> no pulses for the partial word; 3 led_valid with idx 0..2; led_count = 3.
REQ-036 Send 31 zeros, one 1, then 32 zeros -> exactly one frame_start, on the final zero.
REQ-037 Assert rst after the 16th bit of a data frame, release it, then send a full packet of 2 LEDs -> all outputs read 0 during reset; led_valid idx 0 and 1 only; led_count = 2.
